bram_dac_reader: RTL
====================

Name: bram_dac_reader

Overview:
- Read-side engine for the DAC waveform BRAM. The PLB side writes samples through port A; this block sequences reads from start_addr to end_addr.
- Each BRAM word is presented to the DAC data pins at a programmable sample rate, with optional looping.
- Sits between the bram_arb read port and the DAC pin drivers inside plb_dac.

Parameters:
- ADDR_W, 16, BRAM word address width
- DATA_W, 10, DAC sample width
- DIV_W, 16, sample-rate divider width
- MIDSCALE, 10'h200, DAC idle/reset code (offset-binary zero)

Ports:
- clka  in  1  system clock
- rsta_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse: begin playback
- stop  in  1  one-cycle pulse: abort playback
- loop_en  in  1  1 = wrap end_addr back to start_addr
- start_addr  in  ADDR_W  first sample address
- end_addr  in  ADDR_W  last sample address (inclusive)
- rate_div  in  DIV_W  sample period = rate_div+1 clka cycles
- mem_addr  out  ADDR_W  BRAM read address (registered)
- mem_dout  in  DATA_W  BRAM read data, 1-cycle latency after address sampled
- dac_data  out  DATA_W  held DAC code
- dac_valid  out  1  one-cycle strobe when dac_data updates
- busy  out  1  high in PRIME/RUN
- done  out  1  one-cycle pulse on natural end of a non-loop run
- cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (rsta_n=0 at edge): state IDLE, mem_addr=0, dac_data=MIDSCALE, dac_valid=0, busy=0, done=0, cfg_err=0, div_cnt=0.
- Reset has priority over all inputs and aborts a run immediately.
- Effective divider: eff_div = (rate_div==0) ? 1 : rate_div. The minimum period is 2 cycles, which guarantees BRAM latency is met.
- start_addr, end_addr, loop_en and eff_div are latched at accepted start. Input changes during a run are ignored.
- FSM IDLE:
  - If start=1 and start_addr>end_addr, pulse cfg_err and stay IDLE.
  - If start=1 otherwise, set mem_addr<=start_addr and go to PRIME.
- FSM PRIME: lasts one cycle, clears div_cnt, then goes to RUN. busy=1.
- FSM RUN: div_cnt increments each cycle. A tick occurs when div_cnt==eff_div. On tick:
  - div_cnt<=0.
  - dac_data<=mem_dout and dac_valid=1 in the following cycle.
  - If mem_addr!=end_addr, mem_addr<=mem_addr+1.
  - If mem_addr==end_addr and loop_en=1, mem_addr<=start_addr_latched and stay in RUN.
  - If mem_addr==end_addr and loop_en=0, go to IDLE and pulse done in the same cycle as the final dac_valid.
- Latency: with start sampled at edge 0, the first dac_data update is at edge eff_div+2. Later updates follow every eff_div+1 edges.
- start_addr==end_addr is legal: single sample. With loop_en=1 the same sample repeats.
- stop in PRIME or RUN: go to IDLE at that edge with no dac_valid and no done. dac_data keeps its last value.
- stop has priority over a coincident tick.
- start while busy is ignored. start and stop together in IDLE: stop wins and there is no run.
- mem_addr never exceeds end_addr. There is no wrap at 2^ADDR_W because end_addr bounds the range.
- In IDLE, mem_addr holds its last value.

Decomposition:
- Shared header dac_defs.vh holds:
  - the FSM state encodings (IDLE=2'd0, PRIME=2'd1, RUN=2'd2)
  - the ADDR_W/DATA_W/DIV_W defaults
  - the MIDSCALE constant
- One sub-module, sample_tick_gen: divider counter with clear input, eff_div clamp, and tick output. It is reused by the ADC capture path.

Test Plan:
- Preload BRAM addrs 20..23 = 100,101,102,103. Send start with start=20, end=23, rate_div=3, loop_en=0. Expect dac_valid at edges 5,9,13,17 carrying 100..103, done coincident with the last valid, then busy=0.
- Same preload with loop_en=1 and rate_div=1. Expect the sequence 100,101,102,103,100,101 at 2-cycle spacing. Assert stop after the 6th valid: expect no 7th valid, dac_data stays 101, done never pulses.
- start_addr=40, end_addr=39 -> cfg_err pulses once, busy stays 0, mem_addr unchanged.
- rate_div=0, start=end=40, BRAM[40]=233 -> single valid with 233 at edge 3, then done.
- Pull rsta_n low mid-run after the second sample -> next cycle dac_data=10'h200, busy=0, mem_addr=0, and no done.
- start pulsed again while busy -> ignored; the address sequence and timing are identical to the single-start run.

Source files
------------

// File: rtl/bram_dac_reader_pkg.sv
`default_nettype none
// ============================================================
// bram_dac_reader_pkg : shared widths, idle code, FSM states
// Rev 1.0
// ============================================================
package bram_dac_reader_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 10;
  localparam int DIV_W_DEF  = 16;

  // Offset-binary zero: the DAC sits at mid-rail when idle
  localparam logic [9:0] MIDSCALE_DEF = 10'h200;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bram_dac_reader_sample_tick_gen.sv
`default_nettype none
// ============================================================
// sample_tick_gen : divider counter producing a sample tick
// Rev 1.0
// ============================================================
module sample_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_eff_div;
  logic             w_tick;

  // A divider of zero would leave no cycle for BRAM read latency
  assign w_eff_div = (div == '0) ? DIV_W'(1) : div;
  assign w_tick    = en && (r_cnt == w_eff_div);
  assign tick      = w_tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_dac_reader.sv
`default_nettype none
// ============================================================
// bram_dac_reader : sequences BRAM reads onto the DAC pins
// Rev 1.0
// ============================================================
module bram_dac_reader
  import bram_dac_reader_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                DIV_W    = DIV_W_DEF,
  parameter logic [DATA_W-1:0] MIDSCALE = MIDSCALE_DEF
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DIV_W-1:0]  rate_div,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_dac_data;
  logic              r_dac_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_cfg_err;
  logic [ADDR_W-1:0] r_start_addr;
  logic [ADDR_W-1:0] r_end_addr;
  logic              r_loop_en;
  logic [DIV_W-1:0]  r_rate_div;

  logic w_run;
  logic w_clr;
  logic w_tick;

  assign w_run = (r_state == ST_RUN);
  assign w_clr = !w_run;

  sample_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk   (clka),
    .rst_n (rsta_n),
    .clr   (w_clr),
    .en    (w_run),
    .div   (r_rate_div),
    .tick  (w_tick)
  );

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      r_state      <= ST_IDLE;
      r_mem_addr   <= '0;
      r_dac_data   <= MIDSCALE;
      r_dac_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_start_addr <= '0;
      r_end_addr   <= '0;
      r_loop_en    <= 1'b0;
      r_rate_div   <= '0;
    end else begin
      r_dac_valid <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // stop beside start cancels the request outright
          if (start && !stop) begin
            if (start_addr > end_addr) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_start_addr <= start_addr;
              r_end_addr   <= end_addr;
              r_loop_en    <= loop_en;
              r_rate_div   <= rate_div;
              r_mem_addr   <= start_addr;
              r_busy       <= 1'b1;
              r_state      <= ST_PRIME;
            end
          end
        end
        ST_PRIME: begin
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            r_dac_data  <= mem_dout;
            r_dac_valid <= 1'b1;
            if (r_mem_addr != r_end_addr) begin
              r_mem_addr <= r_mem_addr + ADDR_W'(1);
            end else if (r_loop_en) begin
              r_mem_addr <= r_start_addr;
            end else begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign dac_data  = r_dac_data;
  assign dac_valid = r_dac_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire
